// File: rtl/sb_pkg.sv
// sb_pkg: shared widths and decoder opcode constants for the dual-issue scoreboard.
package sb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] OP_OP32 = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  function automatic logic is_long_lat(input logic [6:0] opcode, input logic [6:0] funct7);
    return opcode == OP_LOAD || opcode == OP_SYSTEM ||
           ((opcode == OP_OP || opcode == OP_OP32) && funct7 == FUNCT7_MULDIV);
  endfunction
endpackage

// File: rtl/sb_hazard_check.sv
// sb_hazard_check: RAW/WAW check of one decoded instruction against the effective busy bitmap.
module sb_hazard_check
  import sb_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic [NUM_REGS-1:0]   eff_i,
  input  logic [REG_ADDR_W-1:0] rs1Addr_i,
  input  logic [REG_ADDR_W-1:0] rs2Addr_i,
  input  logic                  rs1ReadEnable_i,
  input  logic                  rs2ReadEnable_i,
  input  logic [REG_ADDR_W-1:0] rdAddr_i,
  input  logic                  rdWriteEnable_i,
  input  logic                  longLat_i,
  output logic                  writesRd_o,
  output logic                  haz_o
);
  assign writesRd_o = (rdWriteEnable_i | longLat_i) & (rdAddr_i != '0);
  assign haz_o = (rs1ReadEnable_i & eff_i[rs1Addr_i]) |
                 (rs2ReadEnable_i & eff_i[rs2Addr_i]) |
                 (writesRd_o & eff_i[rdAddr_i]);
endmodule

// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: in-order pair issue with a busy bitmap for long-latency rd targets.
module dual_issue_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter bit WB_BYPASS = 1'b1,
  parameter int PERF_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  way0_valid_i,
  input  logic [1:0]            way0_pID_i,
  input  logic [REG_ADDR_W-1:0] way0_rs1Addr_i,
  input  logic [REG_ADDR_W-1:0] way0_rs2Addr_i,
  input  logic                  way0_rs1ReadEnable_i,
  input  logic                  way0_rs2ReadEnable_i,
  input  logic [REG_ADDR_W-1:0] way0_rdAddr_i,
  input  logic                  way0_rdWriteEnable_i,
  input  logic                  way0_longLat_i,
  input  logic                  way1_valid_i,
  input  logic [1:0]            way1_pID_i,
  input  logic [REG_ADDR_W-1:0] way1_rs1Addr_i,
  input  logic [REG_ADDR_W-1:0] way1_rs2Addr_i,
  input  logic                  way1_rs1ReadEnable_i,
  input  logic                  way1_rs2ReadEnable_i,
  input  logic [REG_ADDR_W-1:0] way1_rdAddr_i,
  input  logic                  way1_rdWriteEnable_i,
  input  logic                  way1_longLat_i,
  input  logic                  ex_ready_i,
  input  logic                  wb0_valid_i,
  input  logic [REG_ADDR_W-1:0] wb0_addr_i,
  input  logic                  wb1_valid_i,
  input  logic [REG_ADDR_W-1:0] wb1_addr_i,
  input  logic                  flush_i,
  output logic                  way0_ready_o,
  output logic [1:0]            way0_pID_o,
  output logic                  way1_ready_o,
  output logic [1:0]            way1_pID_o,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic [PERF_W-1:0]     stall_cnt_o
);
  logic [NUM_REGS-1:0] r_busy, w_clr, w_set, w_eff;
  logic [PERF_W-1:0]   r_stall_cnt;
  logic                w_haz0, w_haz1, w_wr0, w_wr1, w_pair_raw, w_pair_waw;
  always_comb begin
    w_clr = '0;
    if (wb0_valid_i) w_clr[wb0_addr_i] = 1'b1;
    if (wb1_valid_i) w_clr[wb1_addr_i] = 1'b1;
    w_eff = WB_BYPASS ? r_busy & ~w_clr : r_busy;
    w_eff[0] = 1'b0;
  end
  sb_hazard_check #(.NUM_REGS(NUM_REGS)) u_chk0 (
    .eff_i(w_eff), .rs1Addr_i(way0_rs1Addr_i), .rs2Addr_i(way0_rs2Addr_i),
    .rs1ReadEnable_i(way0_rs1ReadEnable_i), .rs2ReadEnable_i(way0_rs2ReadEnable_i),
    .rdAddr_i(way0_rdAddr_i), .rdWriteEnable_i(way0_rdWriteEnable_i),
    .longLat_i(way0_longLat_i), .writesRd_o(w_wr0), .haz_o(w_haz0)
  );
  sb_hazard_check #(.NUM_REGS(NUM_REGS)) u_chk1 (
    .eff_i(w_eff), .rs1Addr_i(way1_rs1Addr_i), .rs2Addr_i(way1_rs2Addr_i),
    .rs1ReadEnable_i(way1_rs1ReadEnable_i), .rs2ReadEnable_i(way1_rs2ReadEnable_i),
    .rdAddr_i(way1_rdAddr_i), .rdWriteEnable_i(way1_rdWriteEnable_i),
    .longLat_i(way1_longLat_i), .writesRd_o(w_wr1), .haz_o(w_haz1)
  );
  // The younger way may only ride along with the older one, never alone.
  assign w_pair_raw = w_wr0 & ((way1_rs1ReadEnable_i & (way1_rs1Addr_i == way0_rdAddr_i)) |
                               (way1_rs2ReadEnable_i & (way1_rs2Addr_i == way0_rdAddr_i)));
  assign w_pair_waw = w_wr0 & w_wr1 & (way0_rdAddr_i == way1_rdAddr_i);
  assign way0_ready_o = ~rst & way0_valid_i & ex_ready_i & ~flush_i & ~w_haz0;
  assign way1_ready_o = way0_ready_o & way1_valid_i & ~w_haz1 & ~w_pair_raw & ~w_pair_waw;
  assign way0_pID_o = way0_ready_o ? way0_pID_i : 2'd0;
  assign way1_pID_o = way1_ready_o ? way1_pID_i : 2'd0;
  always_comb begin
    w_set = '0;
    if (way0_ready_o && way0_longLat_i && way0_rdAddr_i != '0) w_set[way0_rdAddr_i] = 1'b1;
    if (way1_ready_o && way1_longLat_i && way1_rdAddr_i != '0) w_set[way1_rdAddr_i] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= flush_i ? '0 : (r_busy & ~w_clr) | w_set;
      if (way0_valid_i && !way0_ready_o && !flush_i && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
  assign busy_o = r_busy;
  assign stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard: directed steps with hand-computed expectations for the scoreboard.
module tb_dual_issue_scoreboard;
  logic clk = 1'b0, rst;
  logic v0, re01, re02, we0, ll0, v1, re11, re12, we1, ll1;
  logic [1:0] pid0, pid1, pid0_o, pid1_o;
  logic [4:0] rs01, rs02, rd0, rs11, rs12, rd1, wb0_a, wb1_a;
  logic ex_ready, wb0_v, wb1_v, flush, rdy0, rdy1;
  logic [31:0] busy, stall;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dual_issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .way0_valid_i(v0), .way0_pID_i(pid0), .way0_rs1Addr_i(rs01), .way0_rs2Addr_i(rs02),
    .way0_rs1ReadEnable_i(re01), .way0_rs2ReadEnable_i(re02), .way0_rdAddr_i(rd0),
    .way0_rdWriteEnable_i(we0), .way0_longLat_i(ll0),
    .way1_valid_i(v1), .way1_pID_i(pid1), .way1_rs1Addr_i(rs11), .way1_rs2Addr_i(rs12),
    .way1_rs1ReadEnable_i(re11), .way1_rs2ReadEnable_i(re12), .way1_rdAddr_i(rd1),
    .way1_rdWriteEnable_i(we1), .way1_longLat_i(ll1),
    .ex_ready_i(ex_ready), .wb0_valid_i(wb0_v), .wb0_addr_i(wb0_a),
    .wb1_valid_i(wb1_v), .wb1_addr_i(wb1_a), .flush_i(flush),
    .way0_ready_o(rdy0), .way0_pID_o(pid0_o), .way1_ready_o(rdy1), .way1_pID_o(pid1_o),
    .busy_o(busy), .stall_cnt_o(stall)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {v0, re01, re02, we0, ll0, v1, re11, re12, we1, ll1} = '0;
    {pid0, pid1, rs01, rs02, rd0, rs11, rs12, rd1} = '0;
    {wb0_v, wb1_v, wb0_a, wb1_a, flush} = '0;
    ex_ready = 1'b1;
  endtask
  task automatic w0(input logic [1:0] p, input logic [4:0] a, input logic ea, input logic [4:0] b,
                    input logic eb, input logic [4:0] d, input logic we, input logic ll);
    v0 = 1'b1; pid0 = p; rs01 = a; re01 = ea; rs02 = b; re02 = eb; rd0 = d; we0 = we; ll0 = ll;
  endtask
  task automatic w1(input logic [1:0] p, input logic [4:0] a, input logic ea, input logic [4:0] b,
                    input logic eb, input logic [4:0] d, input logic we, input logic ll);
    v1 = 1'b1; pid1 = p; rs11 = a; re11 = ea; rs12 = b; re12 = eb; rd1 = d; we1 = we; ll1 = ll;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    idle();
    w0(2'd1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    #2;
    chk("rst_ready0", {31'd0, rdy0}, 0);
    chk("rst_pid0", {30'd0, pid0_o}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("add_ready", {31'd0, rdy0}, 1);
    chk("add_pid", {30'd0, pid0_o}, 1);
    tick();
    chk("add_busy", busy, 0);
    idle(); w0(2'd2, 5'd1, 1, 5'd0, 0, 5'd7, 0, 1); #1;
    chk("ld7_ready", {31'd0, rdy0}, 1);
    tick();
    chk("ld7_busy", busy, 32'h80);
    idle(); w0(2'd3, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0); #1;
    chk("raw_stall", {31'd0, rdy0}, 0);
    chk("raw_pid", {30'd0, pid0_o}, 0);
    tick();
    chk("stall_1", stall, 1);
    tick();
    chk("stall_2", stall, 2);
    wb0_v = 1'b1; wb0_a = 5'd7; #1;
    chk("wb_bypass_ready", {31'd0, rdy0}, 1);
    tick();
    chk("wb_busy_clr", busy, 0);
    chk("stall_hold", stall, 2);
    idle(); w0(2'd1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0); w1(2'd2, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0); #1;
    chk("pair_raw_r0", {31'd0, rdy0}, 1);
    chk("pair_raw_r1", {31'd0, rdy1}, 0);
    chk("pair_raw_pid1", {30'd0, pid1_o}, 0);
    tick();
    idle(); w0(2'd2, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0); #1;
    chk("reissue_r0", {31'd0, rdy0}, 1);
    tick();
    idle(); w0(2'd1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0); w1(2'd3, 5'd1, 1, 5'd2, 1, 5'd11, 1, 0); #1;
    chk("pair_ok_r1", {31'd0, rdy1}, 1);
    chk("pair_ok_pid1", {30'd0, pid1_o}, 3);
    rd1 = 5'd10; #1;
    chk("pair_waw_r1", {31'd0, rdy1}, 0);
    rd0 = 5'd0; rd1 = 5'd0; #1;
    chk("pair_x0_r1", {31'd0, rdy1}, 1);
    tick();
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd9, 0, 1); tick();
    chk("ld9_busy", busy, 32'h200);
    idle(); w0(2'd1, 5'd9, 1, 5'd0, 1, 5'd1, 1, 0); w1(2'd2, 5'd5, 1, 5'd6, 1, 5'd2, 1, 0); #1;
    chk("inorder_r0", {31'd0, rdy0}, 0);
    chk("inorder_r1", {31'd0, rdy1}, 0);
    chk("inorder_pids", {28'd0, pid0_o, pid1_o}, 0);
    tick();
    chk("stall_3", stall, 3);
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd0, 0, 1); #1;
    chk("ld_x0_ready", {31'd0, rdy0}, 1);
    tick();
    chk("ld_x0_busy", busy, 32'h200);
    idle(); w0(2'd0, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0); #1;
    chk("waw_stall", {31'd0, rdy0}, 0);
    tick();
    chk("stall_4", stall, 4);
    idle(); wb1_v = 1'b1; wb1_a = 5'd9; tick();
    chk("wb1_clr", busy, 0);
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd7, 0, 1); w1(2'd1, 5'd1, 1, 5'd0, 0, 5'd12, 0, 1); tick();
    chk("pair_ld_busy", busy, 32'h1080);
    idle(); flush = 1'b1; w0(2'd2, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0); #1;
    chk("flush_no_issue", {31'd0, rdy0}, 0);
    tick();
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 4);
    idle(); wb0_v = 1'b1; wb0_a = 5'd7; tick();
    chk("late_wb_busy", busy, 0);
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd7, 0, 1); tick();
    wb0_v = 1'b1; wb0_a = 5'd7; #1;
    chk("set_clr_ready", {31'd0, rdy0}, 1);
    tick();
    chk("set_wins", busy, 32'h80);
    idle(); wb1_v = 1'b1; wb1_a = 5'd7; tick();
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd7, 0, 1); w1(2'd1, 5'd1, 1, 5'd0, 0, 5'd8, 0, 1); tick();
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd9, 0, 1); w1(2'd1, 5'd1, 1, 5'd0, 0, 5'd10, 0, 1); tick();
    idle(); w0(2'd0, 5'd1, 1, 5'd0, 0, 5'd11, 0, 1); tick();
    chk("busy_f80", busy, 32'hF80);
    chk("stall_pre_rst", stall, 4);
    idle(); w0(2'd3, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0); #1;
    chk("pre_rst_ready", {31'd0, rdy0}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ready", {31'd0, rdy0}, 0);
    chk("async_pid", {30'd0, pid0_o}, 0);
    chk("async_stall", stall, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
